alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue/writeback sequencer that drives the 16-bit ALU from the initiator side. It accepts one 16-bit instruction per handshake and decodes it to the ALU's 4-bit opcode. It reads operands from the register file, presents them to the ALU, holds them stable for a fixed number of cycles, then captures the ALU outputs and performs register writeback. It also maintains the zero flag and the sticky overflow/illegal-instruction exception state.

Parameters:
ALU_LATENCY, 1, cycles operands/opcode are held on the ALU before its outputs are sampled; legal range 1-15.
SIGN_EXT_IMM, 1, 1 = ADDI imm4 is sign-extended to 16 bits; 0 = zero-extended.

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction available
instr_ready  out  1  block can accept an instruction
instr  in  16  [15:12] op, [11:8] rs, [7:4] rt, [3:0] rd (R-type) or imm4 (op 0010)
rf_raddr_a  out  4  register file read address A (= rs)
rf_raddr_b  out  4  register file read address B (= rt)
rf_rdata_a  in  16  combinational read data A
rf_rdata_b  in  16  combinational read data B
alu_a  out  16  ALU operand A
alu_b  out  16  ALU operand B
alu_opcode  out  4  ALU opcode
alu_out  in  16  ALU result
alu_overflow  in  1  ALU overflow flag
alu_zero  in  1  ALU zero flag
wb_en  out  1  one-cycle register write strobe
wb_addr  out  4  write register
wb_data  out  16  write data
zero_flag  out  1  result of the last SUB was zero
exc_pending  out  1  sticky exception; blocks issue
exc_cause  out  2  01 = overflow, 10 = illegal opcode, 00 = none
exc_clear  in  1  clears exc_pending/exc_cause
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; instr_ready=0 during the reset cycle and 1 in the first cycle after it; wb_en=0; wb_addr=0; wb_data=0; alu_a=0; alu_b=0; alu_opcode=0; rf_raddr_a=0; rf_raddr_b=0; zero_flag=0; exc_pending=0; exc_cause=00; busy=0.
- Opcode map (passed through unchanged to alu_opcode): 0000 ADD, 0001 SUB, 0010 ADDI, 0011 AND, 0100 OR, 0101 NOT (uses rs only), 0110 SLL, 0111 SRL (shift amount = rt value). Opcodes 1000-1111 are illegal.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - instr_ready = !exc_pending.
  - On instr_valid && instr_ready: latch instr, go to READ.
- READ:
  - rf_raddr_a/b driven from the latched rs/rt.
  - Capture opA = rf_rdata_a.
  - Capture opB = rf_rdata_b, or ext(imm4) for ADDI.
  - Illegal opcode: set exc_pending=1 and exc_cause=10, go to IDLE. No ALU cycle, no writeback.
  - Otherwise go to EXEC, loading the hold counter with ALU_LATENCY-1.
- EXEC:
  - alu_a, alu_b and alu_opcode are registered and stable for exactly ALU_LATENCY cycles.
  - When the counter reaches 0, sample alu_out, alu_overflow and alu_zero, then go to WB.
- WB, one cycle:
  - If the sampled overflow = 1 (ADD/SUB/ADDI only): wb_en=0, exc_pending=1, exc_cause=01.
  - Otherwise wb_en=1, wb_data = sampled result.
  - wb_addr = rd for R-type, rt for ADDI.
  - A destination of r0 forces wb_en=0; it is not an exception.
  - On SUB without overflow: zero_flag = sampled alu_zero. zero_flag holds for all other ops.
  - Go to IDLE.
- Latency: handshake accepted in cycle T gives wb_en high in cycle T+2+ALU_LATENCY. The next accept is possible no earlier than T+3+ALU_LATENCY. Throughput is one instruction per 3+ALU_LATENCY cycles.
- instr_ready is 0 in every state except IDLE. instr_valid in non-IDLE states is ignored; the initiator must hold the instruction until it is accepted.
- exc_clear:
  - Clears exc_pending/exc_cause on the next edge.
  - If it coincides with a new exception being set (READ illegal or WB overflow), the new exception wins.
- Reset asserted in any state returns all outputs to their reset values on that edge and aborts the in-flight instruction with no writeback.

Test Plan:
1. ADD, r1=0x0005, r2=0x0003, instr 0x0123 (ALU_LATENCY=1) -> wb_en pulse 3 cycles after accept, wb_addr=3, wb_data=0x0008, exc_pending=0.
2. ADDI, r4=0x0010, instr 0x243F (imm=0xF, SIGN_EXT_IMM=1) -> alu_b=0xFFFF, wb_addr=3, wb_data=0x000F.
3. SUB r5-r5 with r5=0x1234, instr 0x1556 -> wb_data=0x0000, wb_addr=6, zero_flag=1. A following AND leaves zero_flag=1.
4. ADD, r1=0x7FFF, r2=0x0001 -> alu_overflow=1, no wb_en, exc_pending=1, exc_cause=01, instr_ready=0 until exc_clear. One cycle after exc_clear: instr_ready=1.
5. Illegal instr 0x9123 -> exc_cause=10 two cycles after accept, alu_opcode never 1001, no wb_en. ADD to rd=0 (0x0120) -> no wb_en, no exception.
6. ALU_LATENCY=3: alu_a/alu_b/alu_opcode stable 3 cycles. Assert reset during the second EXEC cycle -> next cycle all outputs at reset values, no wb_en.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the 16-bit ALU: decode, operand fetch, timed hold,
// result capture and register writeback with sticky exception tracking.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LATENCY  = 1,
  parameter bit          SIGN_EXT_IMM = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        zero_flag,
  output logic        exc_pending,
  output logic [1:0]  exc_cause,
  input  logic        exc_clear,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;

  state_t      stateR;
  state_t      stateNextS;
  logic [15:0] instrR;
  logic [3:0]  holdCntR;
  logic        excPendingNextS;
  logic [1:0]  excCauseNextS;
  logic [3:0]  opS;
  logic        illegalS;
  logic        ovfTrapS;
  logic        acceptS;
  logic [3:0]  destS;

  function automatic logic [15:0] extImm(input logic [3:0] imm);
    if (SIGN_EXT_IMM) begin
      extImm = {{12{imm[3]}}, imm};
    end else begin
      extImm = {12'h000, imm};
    end
  endfunction

  assign opS      = instrR[15:12];
  assign illegalS = instrR[15];
  // Overflow is only an exception for the arithmetic ops ADD/SUB/ADDI.
  assign ovfTrapS = alu_overflow && (opS inside {4'h0, 4'h1, 4'h2});
  assign acceptS  = instr_valid && instr_ready;
  assign destS    = (opS == OP_ADDI) ? instrR[7:4] : instrR[3:0];

  // Next state and next exception state; a newly raised exception beats exc_clear.
  always_comb begin
    stateNextS      = stateR;
    excPendingNextS = exc_pending;
    excCauseNextS   = exc_cause;
    if (exc_clear) begin
      excPendingNextS = 1'b0;
      excCauseNextS   = 2'b00;
    end else begin
      excPendingNextS = exc_pending;
      excCauseNextS   = exc_cause;
    end
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          stateNextS = READ;
        end else begin
          stateNextS = IDLE;
        end
      end
      READ: begin
        if (illegalS) begin
          stateNextS      = IDLE;
          excPendingNextS = 1'b1;
          excCauseNextS   = 2'b10;
        end else begin
          stateNextS = EXEC;
        end
      end
      EXEC: begin
        if (holdCntR == 4'd0) begin
          stateNextS = WB;
          if (ovfTrapS) begin
            excPendingNextS = 1'b1;
            excCauseNextS   = 2'b01;
          end else begin
            excPendingNextS = excPendingNextS;
          end
        end else begin
          stateNextS = EXEC;
        end
      end
      WB:      stateNextS = IDLE;
      default: stateNextS = IDLE;
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateR      <= IDLE;
      instrR      <= 16'h0000;
      holdCntR    <= 4'd0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      rf_raddr_a  <= 4'd0;
      rf_raddr_b  <= 4'd0;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
      alu_opcode  <= 4'd0;
      wb_en       <= 1'b0;
      wb_addr     <= 4'd0;
      wb_data     <= 16'h0000;
      zero_flag   <= 1'b0;
      exc_pending <= 1'b0;
      exc_cause   <= 2'b00;
    end else begin
      stateR      <= stateNextS;
      exc_pending <= excPendingNextS;
      exc_cause   <= excCauseNextS;
      instr_ready <= (stateNextS == IDLE) && !excPendingNextS;
      busy        <= (stateNextS != IDLE);
      wb_en       <= 1'b0;
      case (stateR)
        IDLE: begin
          if (acceptS) begin
            instrR     <= instr;
            rf_raddr_a <= instr[11:8];
            rf_raddr_b <= instr[7:4];
          end
        end
        READ: begin
          if (!illegalS) begin
            alu_a      <= rf_rdata_a;
            alu_b      <= (opS == OP_ADDI) ? extImm(instrR[3:0]) : rf_rdata_b;
            alu_opcode <= opS;
            holdCntR   <= 4'(ALU_LATENCY - 1);
          end
        end
        EXEC: begin
          if (holdCntR == 4'd0) begin
            wb_data <= alu_out;
            wb_addr <= destS;
            wb_en   <= !ovfTrapS && (destS != 4'd0);
            if ((opS == OP_SUB) && !alu_overflow) begin
              zero_flag <= alu_zero;
            end
          end else begin
            holdCntR <= holdCntR - 4'd1;
          end
        end
        WB:      holdCntR <= 4'd0;
        default: holdCntR <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance at ALU_LATENCY=1 and one at 3,
// with a behavioural register file and ALU around them.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rf [16];

  // Instance with ALU_LATENCY = 1
  logic        reset, valid, ready, excClear, wbEn, zeroFlag, excPending, busy, aluOvf, aluZero;
  logic [15:0] instr, rdataA, rdataB, aluA, aluB, aluOut, wbData;
  logic [3:0]  raddrA, raddrB, aluOp, wbAddr;
  logic [1:0]  excCause;

  // Instance with ALU_LATENCY = 3
  logic        reset3, valid3, ready3, excClear3, wbEn3, zeroFlag3, excPending3, busy3, aluOvf3, aluZero3;
  logic [15:0] instr3, rdataA3, rdataB3, aluA3, aluB3, aluOut3, wbData3;
  logic [3:0]  raddrA3, raddrB3, aluOp3, wbAddr3;
  logic [1:0]  excCause3;

  int nChecks = 0;
  int nPass   = 0;

  function automatic logic [17:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      4'h0, 4'h2: begin r = a + b; ovf = (a[15] == b[15]) && (r[15] != a[15]); end
      4'h1:       begin r = a - b; ovf = (a[15] != b[15]) && (r[15] != a[15]); end
      4'h3:       r = a & b;
      4'h4:       r = a | b;
      4'h5:       r = ~a;
      4'h6:       r = a << b[3:0];
      4'h7:       r = a >> b[3:0];
      default:    r = 16'h0000;
    endcase
    return {ovf, (r == 16'h0000), r};
  endfunction

  assign rdataA  = rf[raddrA];
  assign rdataB  = rf[raddrB];
  assign rdataA3 = rf[raddrA3];
  assign rdataB3 = rf[raddrB3];
  assign {aluOvf, aluZero, aluOut}    = aluModel(aluOp, aluA, aluB);
  assign {aluOvf3, aluZero3, aluOut3} = aluModel(aluOp3, aluA3, aluB3);

  alu_issue_ctrl #(.ALU_LATENCY(1), .SIGN_EXT_IMM(1'b1)) dut (
    .clock(clk), .reset(reset), .instr_valid(valid), .instr_ready(ready), .instr(instr),
    .rf_raddr_a(raddrA), .rf_raddr_b(raddrB), .rf_rdata_a(rdataA), .rf_rdata_b(rdataB),
    .alu_a(aluA), .alu_b(aluB), .alu_opcode(aluOp), .alu_out(aluOut),
    .alu_overflow(aluOvf), .alu_zero(aluZero), .wb_en(wbEn), .wb_addr(wbAddr),
    .wb_data(wbData), .zero_flag(zeroFlag), .exc_pending(excPending), .exc_cause(excCause),
    .exc_clear(excClear), .busy(busy)
  );

  alu_issue_ctrl #(.ALU_LATENCY(3), .SIGN_EXT_IMM(1'b1)) dut3 (
    .clock(clk), .reset(reset3), .instr_valid(valid3), .instr_ready(ready3), .instr(instr3),
    .rf_raddr_a(raddrA3), .rf_raddr_b(raddrB3), .rf_rdata_a(rdataA3), .rf_rdata_b(rdataB3),
    .alu_a(aluA3), .alu_b(aluB3), .alu_opcode(aluOp3), .alu_out(aluOut3),
    .alu_overflow(aluOvf3), .alu_zero(aluZero3), .wb_en(wbEn3), .wb_addr(wbAddr3),
    .wb_data(wbData3), .zero_flag(zeroFlag3), .exc_pending(excPending3), .exc_cause(excCause3),
    .exc_clear(excClear3), .busy(busy3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns in the cycle after acceptance (READ).
  task automatic issue(input bit useL3, input logic [15:0] ins);
    for (int i = 0; i < 20 && !(useL3 ? ready3 : ready); i++) step();
    if (!(useL3 ? ready3 : ready)) checkVal("readyTimeout", 32'h0, 32'h1);
    if (useL3) begin valid3 = 1'b1; instr3 = ins; end
    else       begin valid  = 1'b1; instr  = ins; end
    step();
    valid = 1'b0; valid3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    reset = 1'b1; reset3 = 1'b1; valid = 1'b0; valid3 = 1'b0;
    instr = 16'h0000; instr3 = 16'h0000; excClear = 1'b0; excClear3 = 1'b0;
    step(); step();
    checkVal("rstReady",   32'(ready),      32'h0);
    checkVal("rstBusy",    32'(busy),       32'h0);
    checkVal("rstWbEn",    32'(wbEn),       32'h0);
    checkVal("rstWbAddr",  32'(wbAddr),     32'h0);
    checkVal("rstWbData",  32'(wbData),     32'h0);
    checkVal("rstAluA",    32'(aluA),       32'h0);
    checkVal("rstAluOp",   32'(aluOp),      32'h0);
    checkVal("rstRaddrA",  32'(raddrA),     32'h0);
    checkVal("rstZero",    32'(zeroFlag),   32'h0);
    checkVal("rstExc",     32'({excPending, excCause}), 32'h0);
    reset = 1'b0; reset3 = 1'b0;
    step();
    checkVal("postRstReady", 32'(ready), 32'h1);

    // ADD r1+r2 -> r3
    rf[1] = 16'h0005; rf[2] = 16'h0003;
    issue(1'b0, 16'h0123);
    checkVal("addRaddrA", 32'(raddrA), 32'h1);
    checkVal("addRaddrB", 32'(raddrB), 32'h2);
    checkVal("addBusy",   32'(busy),   32'h1);
    checkVal("addReadyLo",32'(ready),  32'h0);
    step();
    checkVal("addAluA",   32'(aluA),   32'h5);
    checkVal("addAluB",   32'(aluB),   32'h3);
    checkVal("addWbEarly",32'(wbEn),   32'h0);
    step();
    checkVal("addWbEn",   32'(wbEn),   32'h1);
    checkVal("addWbAddr", 32'(wbAddr), 32'h3);
    checkVal("addWbData", 32'(wbData), 32'h8);
    checkVal("addExc",    32'(excPending), 32'h0);
    step();
    checkVal("addWbPulse",32'(wbEn),   32'h0);
    checkVal("addReadyHi",32'(ready),  32'h1);

    // ADDI r4 + sext(0xF) -> r3
    rf[4] = 16'h0010;
    issue(1'b0, 16'h243F);
    step();
    checkVal("addiAluB",  32'(aluB),   32'hFFFF);
    checkVal("addiAluOp", 32'(aluOp),  32'h2);
    step();
    checkVal("addiWbEn",  32'(wbEn),   32'h1);
    checkVal("addiWbAddr",32'(wbAddr), 32'h3);
    checkVal("addiWbData",32'(wbData), 32'hF);
    step();

    // SUB r5-r5 -> r6 sets zero_flag; AND r1&r2 -> r7 leaves it
    rf[5] = 16'h1234;
    issue(1'b0, 16'h1556);
    step(); step();
    checkVal("subWbData", 32'(wbData), 32'h0);
    checkVal("subWbAddr", 32'(wbAddr), 32'h6);
    step();
    checkVal("subZero",   32'(zeroFlag), 32'h1);
    issue(1'b0, 16'h3127);
    step(); step();
    checkVal("andWbData", 32'(wbData), 32'h1);
    checkVal("andWbAddr", 32'(wbAddr), 32'h7);
    step();
    checkVal("andZeroHeld", 32'(zeroFlag), 32'h1);

    // ADD overflow: no writeback, sticky exception until cleared
    rf[1] = 16'h7FFF; rf[2] = 16'h0001;
    issue(1'b0, 16'h0123);
    step(); step();
    checkVal("ovfWbEn",   32'(wbEn),       32'h0);
    checkVal("ovfExc",    32'(excPending), 32'h1);
    checkVal("ovfCause",  32'(excCause),   32'h1);
    step();
    checkVal("ovfReady1", 32'(ready), 32'h0);
    step();
    checkVal("ovfReady2", 32'(ready), 32'h0);
    excClear = 1'b1; step(); excClear = 1'b0;
    checkVal("clrReady",  32'(ready),      32'h1);
    checkVal("clrExc",    32'({excPending, excCause}), 32'h0);

    // Illegal opcode
    issue(1'b0, 16'h9123);
    step();
    checkVal("illCause",  32'(excCause),   32'h2);
    checkVal("illExc",    32'(excPending), 32'h1);
    checkVal("illAluOp",  32'(aluOp),      32'h0);
    checkVal("illWbEn",   32'(wbEn),       32'h0);
    step();
    checkVal("illReady",  32'(ready), 32'h0);
    checkVal("illWbEn2",  32'(wbEn),  32'h0);
    excClear = 1'b1; step(); excClear = 1'b0;
    // New exception beats a coincident clear
    issue(1'b0, 16'hA123);
    excClear = 1'b1; step(); excClear = 1'b0;
    checkVal("illVsClr",  32'({excPending, excCause}), 32'h6);
    excClear = 1'b1; step(); excClear = 1'b0;

    // ADD to r0: no writeback, no exception
    rf[1] = 16'h0005;
    issue(1'b0, 16'h0120);
    step(); step();
    checkVal("r0WbEn",    32'(wbEn),       32'h0);
    checkVal("r0WbAddr",  32'(wbAddr),     32'h0);
    checkVal("r0Exc",     32'(excPending), 32'h0);
    step();
    checkVal("r0Ready",   32'(ready), 32'h1);

    // ALU_LATENCY = 3: three-cycle hold, then writeback
    rf[1] = 16'h0005; rf[2] = 16'h0003;
    issue(1'b1, 16'h0123);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("l3AluA",  32'(aluA3),  32'h5);
      checkVal("l3AluB",  32'(aluB3),  32'h3);
      checkVal("l3AluOp", 32'(aluOp3), 32'h0);
      checkVal("l3NoWb",  32'(wbEn3),  32'h0);
    end
    step();
    checkVal("l3WbEn",    32'(wbEn3),   32'h1);
    checkVal("l3WbData",  32'(wbData3), 32'h8);
    checkVal("l3WbAddr",  32'(wbAddr3), 32'h3);
    step();

    // Reset during the second EXEC cycle aborts the OR
    issue(1'b1, 16'h4125);
    step(); step();
    reset3 = 1'b1;
    step();
    checkVal("abReady",   32'(ready3),   32'h0);
    checkVal("abBusy",    32'(busy3),    32'h0);
    checkVal("abWbEn",    32'(wbEn3),    32'h0);
    checkVal("abWbAddr",  32'(wbAddr3),  32'h0);
    checkVal("abWbData",  32'(wbData3),  32'h0);
    checkVal("abAluA",    32'(aluA3),    32'h0);
    checkVal("abAluB",    32'(aluB3),    32'h0);
    checkVal("abAluOp",   32'(aluOp3),   32'h0);
    checkVal("abRaddrA",  32'(raddrA3),  32'h0);
    reset3 = 1'b0;
    step();
    checkVal("abReadyHi", 32'(ready3), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("abNoWb", 32'(wbEn3), 32'h0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
